// File: rtl/key_register_if.sv
// Write/read port bundle for the AES-128 round-key store.
// Driven by the key-expansion and round-processing logic.
interface key_register_if;
   logic [3:0]   iter_in;
   logic [3:0]   iter_out;
   logic         key_reg_load;
   logic [127:0] key_out;
   logic [127:0] process_key;

   modport master (
      output iter_in,
      output iter_out,
      output key_reg_load,
      output key_out,
      input  process_key
   );

   modport slave (
      input  iter_in,
      input  iter_out,
      input  key_reg_load,
      input  key_out,
      output process_key
   );
endinterface

// File: rtl/key_register.sv
// AES-128 round-key store: 11 x 128-bit slots, written by expansion round and
// read combinationally by processing round; indices 11..15 are inert.
module key_register (
   input logic           clk,
   input logic           n_rst,
   key_register_if.slave bus
);
   localparam int unsigned NumSlots = 11;

   logic [127:0] slot_q [NumSlots];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < NumSlots; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         // Per-slot decode keeps out-of-range indices from touching storage.
         for (int i = 0; i < NumSlots; i++) begin
            if (bus.key_reg_load && (bus.iter_in == 4'(i))) begin
               slot_q[i] <= bus.key_out;
            end
         end
      end
   end

   always_comb begin
      bus.process_key = '0;
      for (int i = 0; i < NumSlots; i++) begin
         if (bus.iter_out == 4'(i)) begin
            bus.process_key = slot_q[i];
         end
      end
   end
endmodule

// File: tb/tb_key_register.sv
// Self-checking bench for key_register against an array-based reference model.
module tb_key_register;
   logic clk = 1'b0;
   logic n_rst;
   int   checks = 0;
   int   errors = 0;
   logic [127:0] model [11];

   key_register_if bus ();

   key_register dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] model_read(input logic [3:0] idx);
      if (idx <= 4'd10) return model[idx];
      return '0;
   endfunction

   function automatic logic [127:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Drives one write cycle from a falling edge to the next falling edge.
   task automatic drive_write(input logic [127:0] k, input logic [3:0] wi,
                              input logic [3:0] ro, input logic ld);
      bus.key_out      = k;
      bus.iter_in      = wi;
      bus.iter_out     = ro;
      bus.key_reg_load = ld;
      @(posedge clk);
      if (ld && wi <= 4'd10) model[wi] = k;
      @(negedge clk);
      bus.key_reg_load = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      n_rst            = 1'b0;
      bus.key_out      = '1;
      bus.iter_in      = 4'd0;
      bus.iter_out     = 4'd0;
      bus.key_reg_load = 1'b1;
      for (int i = 0; i < 11; i++) model[i] = '0;
      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         bus.iter_out = 4'(i);
         #1;
         checks++;
         if (bus.process_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_hold slot %0d: got %h expected 0", i, bus.process_key);
         end
      end
      bus.key_reg_load = 1'b0;
      n_rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         bus.iter_out = 4'(i);
         #1;
         checks++;
         if (bus.process_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_release slot %0d: got %h expected 0", i, bus.process_key);
         end
      end
   endtask

   task automatic test_simple_store();
      drive_write(128'd69, 4'd0, 4'd0, 1'b1);
      checks++;
      if (bus.process_key !== 128'd69) begin
         errors++;
         $display("FAIL simple_store: got %h expected %h", bus.process_key, 128'd69);
      end
   endtask

   task automatic test_second_slot();
      drive_write(128'd74, 4'd4, 4'd4, 1'b1);
      checks++;
      if (bus.process_key !== 128'd74) begin
         errors++;
         $display("FAIL second_slot: got %h expected %h", bus.process_key, 128'd74);
      end
      drive_write(128'd0, 4'd4, 4'd0, 1'b0);
      checks++;
      if (bus.process_key !== 128'd69) begin
         errors++;
         $display("FAIL slot0_retained: got %h expected %h", bus.process_key, 128'd69);
      end
   endtask

   task automatic test_overwrite();
      drive_write(128'd74, 4'd0, 4'd0, 1'b1);
      checks++;
      if (bus.process_key !== 128'd74) begin
         errors++;
         $display("FAIL overwrite_slot0: got %h expected %h", bus.process_key, 128'd74);
      end
      bus.iter_out = 4'd4;
      #1;
      checks++;
      if (bus.process_key !== 128'd74) begin
         errors++;
         $display("FAIL overwrite_slot4: got %h expected %h", bus.process_key, 128'd74);
      end
   endtask

   task automatic test_disabled_out_of_range();
      drive_write('1, 4'd0, 4'd0, 1'b0);
      checks++;
      if (bus.process_key !== model_read(4'd0)) begin
         errors++;
         $display("FAIL load_disabled: got %h expected %h", bus.process_key, model_read(4'd0));
      end
      drive_write(128'hDEAD_BEEF, 4'd12, 4'd0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         bus.iter_out = 4'(i);
         #1;
         checks++;
         if (bus.process_key !== model_read(4'(i))) begin
            errors++;
            $display("FAIL iter_in_12 slot %0d: got %h expected %h", i, bus.process_key,
                     model_read(4'(i)));
         end
      end
      bus.iter_out = 4'd13;
      #1;
      checks++;
      if (bus.process_key !== 128'h0) begin
         errors++;
         $display("FAIL read_iter_13: got %h expected 0", bus.process_key);
      end
   endtask

   task automatic test_full_schedule();
      for (int i = 0; i < 11; i++) drive_write(128'(100 + i), 4'(i), 4'(i), 1'b1);
      for (int i = 0; i < 11; i++) begin
         bus.iter_out = 4'(i);
         #1;
         checks++;
         if (bus.process_key !== 128'(100 + i)) begin
            errors++;
            $display("FAIL schedule slot %0d: got %h expected %h", i, bus.process_key,
                     128'(100 + i));
         end
      end
   endtask

   // Random traffic; also checks the read shows the old value before each write edge.
   task automatic test_random();
      logic [127:0] k;
      logic [3:0]   wi;
      logic [3:0]   ro;
      logic         ld;
      for (int n = 0; n < 300; n++) begin
         k  = rand_key();
         wi = 4'($urandom_range(0, 15));
         ro = ($urandom_range(0, 3) == 0) ? wi : 4'($urandom_range(0, 15));
         ld = 1'($urandom_range(0, 3) != 0);
         bus.key_out      = k;
         bus.iter_in      = wi;
         bus.iter_out     = ro;
         bus.key_reg_load = ld;
         #1;
         checks++;
         if (bus.process_key !== model_read(ro)) begin
            errors++;
            $display("FAIL rand_pre_edge n=%0d idx %0d: got %h expected %h", n, ro,
                     bus.process_key, model_read(ro));
         end
         @(posedge clk);
         if (ld && wi <= 4'd10) model[wi] = k;
         @(negedge clk);
         bus.key_out = rand_key();
         #1;
         checks++;
         if (bus.process_key !== model_read(ro)) begin
            errors++;
            $display("FAIL rand_post_edge n=%0d idx %0d: got %h expected %h", n, ro,
                     bus.process_key, model_read(ro));
         end
      end
      bus.key_reg_load = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 11; i++) drive_write(rand_key() | 128'h1, 4'(i), 4'(i), 1'b1);
      bus.iter_out = 4'd7;
      @(posedge clk);
      #2;
      n_rst = 1'b0;
      #1;
      checks++;
      if (bus.process_key !== 128'h0) begin
         errors++;
         $display("FAIL async_reset_immediate: got %h expected 0", bus.process_key);
      end
      for (int i = 0; i < 11; i++) model[i] = '0;
      bus.key_out      = '1;
      bus.iter_in      = 4'd7;
      bus.key_reg_load = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.process_key !== 128'h0) begin
         errors++;
         $display("FAIL write_during_reset: got %h expected 0", bus.process_key);
      end
      bus.key_reg_load = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 11; i++) begin
         bus.iter_out = 4'(i);
         #1;
         checks++;
         if (bus.process_key !== 128'h0) begin
            errors++;
            $display("FAIL post_reset slot %0d: got %h expected 0", i, bus.process_key);
         end
      end
      drive_write(128'h8000_0000_0000_0000_0000_0000_0000_0001, 4'd10, 4'd10, 1'b1);
      checks++;
      if (bus.process_key !== 128'h8000_0000_0000_0000_0000_0000_0000_0001) begin
         errors++;
         $display("FAIL first_write_after_reset: got %h expected %h", bus.process_key,
                  128'h8000_0000_0000_0000_0000_0000_0000_0001);
      end
   endtask

   initial begin
      test_reset();
      test_simple_store();
      test_second_slot();
      test_overwrite();
      test_disabled_out_of_range();
      test_full_schedule();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_register.md
# key_register

Round-key storage for the AES-128 datapath. It captures each 128-bit round key from the key-expansion logic into a slot selected by the expansion iteration count. It also presents the key for the round currently being processed, so expansion (write side) and encryption/decryption (read side) can run at independent round indices.

## Interface
Parameters: none; widths and depth are fixed.
- clk  input  1  system clock; all storage updates on the rising edge
- n_rst  input  1  reset; asynchronous and active-low; clears all slots
- iter_in  input  4  write slot index (key-expansion round, 0..10)
- iter_out  input  4  read slot index (processing round, 0..10)
- key_reg_load  input  1  write enable, active-high, sampled on the rising edge of clk
- key_out  input  128  round key from the key-expansion block (data to store)
- process_key  output  128  stored round key at slot iter_out

## Operation
- Storage: 11 slots × 128 bits, indexed 0..10, one slot per AES-128 round key.
- Write: on a rising clk edge with key_reg_load=1 and iter_in ≤ 10, slot[iter_in] ← key_out.
  - All other slots hold their values.
  - Writing an already-written slot overwrites it with no restriction.
- Write with key_reg_load=0: no slot changes, regardless of iter_in or key_out.
- Write with iter_in in 11..15: ignored; no slot changes.
- Read: process_key = slot[iter_out], combinational from the stored array; there is no output register.
- Read with iter_out in 11..15: process_key = 128'h0.
- Read and write are independent.
  - Both indices may be equal or differ in the same cycle.
  - There is no write-to-read bypass: the read sees the previously stored value until the write edge.
- Key bit order is preserved exactly; bit 127 of key_out is stored as bit 127 of the slot.

## Timing
- Reset: while n_rst=0, all 11 slots = 0 and process_key = 0, independent of clk.
  - Reset release is synchronous to nothing; the first write can occur on the first rising edge after release.
- Write latency: 1 edge. Data present at edge N is stored at edge N.
- Read latency: combinational.
  - process_key reflects a new slot value immediately after the write edge.
  - process_key reflects a change of iter_out within the same cycle.
- Reset asserted mid-operation: all slots clear immediately. Stored keys are lost; the key schedule must be reloaded.
- Changes to key_out, iter_in or key_reg_load between edges have no effect on storage.
- Only reset and clk edges modify state; no latches.

## Test plan
- Reset: hold n_rst=0 for 1 cycle, then release; iter_out=0..10 -> process_key=0 for every slot.
- Simple store: key_out=69, iter_in=0, iter_out=0, load=1; check at the next falling edge -> process_key=69.
- Second slot: key_out=74, iter_in=4, iter_out=4, load=1 -> process_key=74. Then load=0, key_out=0, iter_out=0 -> process_key=69; slot 0 is retained and unaffected by the slot-4 write.
- Overwrite: key_out=74, iter_in=0, load=1 -> with iter_out=0, process_key=74; with iter_out=4, process_key still 74.
- Load disabled / out of range:
  - load=0, key_out=128'hFFFF…F, iter_in=0 -> slot 0 unchanged.
  - load=1, iter_in=12 -> no slot changes.
  - iter_out=13 -> process_key=0.
- Full schedule and async reset:
  - Write slots 0..10 with values 100+i, then read each back -> 100+i.
  - Assert n_rst mid-cycle, between clock edges -> process_key=0 immediately; all slots read 0 afterwards.
